// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule. It streams the 11 round keys one at a
// time over a valid/ready handshake. Each key is derived on the fly from the
// previous one, so there is no key table.
//
// Ports:
//   clk, rst      rising-edge clock; synchronous active-high reset
//   start         begin a new expansion (sampled only in IDLE)
//   key_in        128-bit cipher key, byte 0 = key_in[0:7] (sampled with start)
//   mode_dec      1 = emit round keys 10..0 (needs KEY_EXPAND_DEC_EN)
//   rk_ready      downstream accepts rk_out this cycle
//   rk_out        current round key, same byte order as key_in
//   rk_valid      rk_out / rk_round valid
//   rk_round      round index of rk_out, 0..10
//   busy          high whenever the FSM is not IDLE
//   done          one-cycle pulse after the final key handshake
//
// Optional feature macro: KEY_EXPAND_DEC_EN compiles in reverse-order emission
// (forward pre-pass to round 10, then inverse steps down to round 0).

// sbox: AES forward S-box byte substitution.
// Latency: combinational.
// Backpressure: none (pure function of the input byte).
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Row r holds S(16*r .. 16*r+15); entry 0 sits in the leftmost byte.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TBL[{a, 3'b000} +: 8];

endmodule

// aes_key_expand: sequential AES-128 round key generator.
// Latency: round 0 is valid one cycle after start; one key per cycle while
// rk_ready is high (the decrypt pre-pass adds ten cycles before round 10).
// Backpressure: rk_out/rk_round hold while rk_valid && !rk_ready.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key_in,
  input  logic         mode_dec,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [0:127] rk_reg, rk_nxt;
  logic [3:0]   round, round_nxt;
  logic [7:0]   rcon, rcon_nxt;
  logic         done_nxt;
  logic         dec_q;
  logic         last_round;

  // Rcon advances by multiplication by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // Word view of the current round key; w0 holds key bytes 0..3, MSB first.
  logic [31:0] w0, w1, w2, w3;
  assign w0 = rk_reg[0:31];
  assign w1 = rk_reg[32:63];
  assign w2 = rk_reg[64:95];
  assign w3 = rk_reg[96:127];

  // One SubWord(RotWord()) path is shared by the forward and inverse steps;
  // only the word fed into it differs.
  logic [31:0] sub_src, rot_w, sub_w;

  assign rot_w = {sub_src[23:0], sub_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    sbox u_sbox (
      .a (rot_w[i*8 +: 8]),
      .y (sub_w[i*8 +: 8])
    );
  end

  // Forward step: round r -> r+1.
  logic [31:0]  f0, f1, f2, f3;
  logic [0:127] fwd_key;

  assign f0      = w0 ^ sub_w ^ {rcon, 24'h0};
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

`ifdef KEY_EXPAND_DEC_EN
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    inv_xtime = r[0] ? ({1'b0, r[7:1]} ^ 8'h8D) : {1'b0, r[7:1]};
  endfunction

  // Inverse step: round r -> r-1. The previous w3 falls out of the XOR chain
  // first and is what the SubWord path needs to rebuild the previous w0.
  logic [31:0]  i0, i1, i2, i3;
  logic [0:127] inv_key;
  logic         dec_nxt;

  assign i3      = w3 ^ w2;
  assign i2      = w2 ^ w1;
  assign i1      = w1 ^ w0;
  assign i0      = w0 ^ sub_w ^ {rcon, 24'h0};
  assign inv_key = {i0, i1, i2, i3};

  // The pre-pass runs forward steps even in decrypt mode.
  assign sub_src = (dec_q && state == EMIT) ? i3 : w3;
`else
  logic unused_mode_dec;

  assign unused_mode_dec = mode_dec;
  assign dec_q           = 1'b0;
  assign sub_src         = w3;
`endif

  assign last_round = dec_q ? (round == 4'd0) : (round == 4'd10);

  always_comb begin
    state_nxt = state;
    rk_nxt    = rk_reg;
    round_nxt = round;
    rcon_nxt  = rcon;
    done_nxt  = 1'b0;
`ifdef KEY_EXPAND_DEC_EN
    dec_nxt   = dec_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          rk_nxt    = key_in;
          round_nxt = 4'd0;
          rcon_nxt  = 8'h01;
`ifdef KEY_EXPAND_DEC_EN
          dec_nxt   = mode_dec;
          state_nxt = mode_dec ? PRE : EMIT;
`else
          state_nxt = EMIT;
`endif
        end
      end
`ifdef KEY_EXPAND_DEC_EN
      PRE: begin
        rk_nxt = fwd_key;
        if (round == 4'd9) begin
          // Round 10 reached; rcon is parked on the value that produced it
          // so the first inverse step can undo exactly that step.
          round_nxt = 4'd10;
          rcon_nxt  = 8'h36;
          state_nxt = EMIT;
        end else begin
          round_nxt = round + 4'd1;
          rcon_nxt  = xtime(rcon);
        end
      end
`endif
      EMIT: begin
        if (rk_ready) begin
          if (last_round) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`ifdef KEY_EXPAND_DEC_EN
          end else if (dec_q) begin
            rk_nxt    = inv_key;
            round_nxt = round - 4'd1;
            rcon_nxt  = inv_xtime(rcon);
`endif
          end else begin
            rk_nxt    = fwd_key;
            round_nxt = round + 4'd1;
            rcon_nxt  = xtime(rcon);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rk_reg <= '0;
      round  <= 4'd0;
      rcon   <= 8'h01;
      done   <= 1'b0;
`ifdef KEY_EXPAND_DEC_EN
      dec_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rk_reg <= rk_nxt;
      round  <= round_nxt;
      rcon   <= rcon_nxt;
      done   <= done_nxt;
`ifdef KEY_EXPAND_DEC_EN
      dec_q  <= dec_nxt;
`endif
    end
  end

  assign rk_out   = rk_reg;
  assign rk_round = round;
  assign rk_valid = (state == EMIT);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: expected round keys are queued as each expansion
// is started and compared as the handshakes occur.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [0:127] key_in = '0;
  logic         mode_dec = 1'b0;
  logic         rk_ready = 1'b0;
  logic [0:127] rk_out;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .mode_dec (mode_dec),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int t0     = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    bit           key_chk;
    int           at;      // expected handshake edge relative to start, -1 = any
    bit           last;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [127:0] fips_rk [11];
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int rnd, input logic [127:0] key, input bit chk,
                      input int at, input bit last);
    exp_t x;
    x.rnd     = rnd[3:0];
    x.key     = key;
    x.key_chk = chk;
    x.at      = at;
    x.last    = last;
    sb.push_back(x);
  endtask

  task automatic start_exp(input logic [127:0] k, input logic md);
    @(posedge clk); #1;
    key_in   = k;
    mode_dec = md;
    start    = 1'b1;
    @(posedge clk); #1;
    t0       = edges;
    start    = 1'b0;
    mode_dec = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input bit rand_ready);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      if (rand_ready) rk_ready = ($urandom_range(0, 1) == 1);
      n++;
    end
    rk_ready = 1'b1;
    check({tag, "_left"}, sb.size(), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_vld"}, rk_valid, 1'b0);
  endtask

  // Monitor: handshakes, done pulse timing and stall stability.
  bit           stall_prev = 1'b0;
  bit           done_exp   = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_rnd;

  always @(negedge clk) begin
    if (mon_en) begin
      check("done", done, done_exp);
      if (stall_prev && !rst) begin
        check("stall_vld", rk_valid, 1'b1);
        check("stall_rnd", rk_round, prev_rnd);
        check("stall_key", rk_out, prev_key);
      end
      done_exp = 1'b0;
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          check("extra_key", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check($sformatf("rnd_%0d", e.rnd), rk_round, e.rnd);
          if (e.key_chk) check($sformatf("key_r%0d", e.rnd), rk_out, e.key);
          if (e.at >= 0) check($sformatf("lat_r%0d", e.rnd), edges + 1 - t0, e.at);
          done_exp = e.last && !rst;
        end
      end
      stall_prev = rk_valid && !rk_ready;
      prev_key   = rk_out;
      prev_rnd   = rk_round;
    end
  end

  initial begin
    fips_rk = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_vld", rk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_key", rk_out, '0);
    check("rst_rnd", rk_round, 4'd0);

    // FIPS-197 key, ready held high: one key per cycle.
    rk_ready = 1'b1;
    for (int k = 0; k <= 10; k++) push(k, fips_rk[k], 1'b1, k + 1, k == 10);
    start_exp(FIPS_KEY, 1'b0);
    check("fips_busy", busy, 1'b1);
    wait_drain("fips", 1'b0);

    // All-zero key: round indices contiguous, round 1 known.
    for (int k = 0; k <= 10; k++)
      push(k, (k == 1) ? ZERO_RK1 : 128'h0, k <= 1, k + 1, k == 10);
    start_exp(128'h0, 1'b0);
    wait_drain("zero", 1'b0);

    // Random backpressure on the FIPS key.
    for (int k = 0; k <= 10; k++) push(k, fips_rk[k], 1'b1, -1, k == 10);
    start_exp(FIPS_KEY, 1'b0);
    wait_drain("bp", 1'b1);

    // start pulsed mid-expansion with another key is ignored.
    for (int k = 0; k <= 10; k++) push(k, fips_rk[k], 1'b1, k + 1, k == 10);
    start_exp(FIPS_KEY, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    key_in = 128'h0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_drain("restart", 1'b0);

    // Reset while round 5 is presented aborts with no done pulse.
    for (int k = 0; k <= 5; k++) push(k, fips_rk[k], 1'b1, k + 1, 1'b0);
    start_exp(FIPS_KEY, 1'b0);
    begin
      int n = 0;
      while (!(rk_valid && rk_round == 4'd5) && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      check("abort_reach_r5", rk_round, 4'd5);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_vld", rk_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_key", rk_out, '0);
    check("abort_rnd", rk_round, 4'd0);
    rst = 1'b0;
    check("abort_left", sb.size(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_done", done, 1'b0);

    // Fresh start after the abort begins again at round 0.
    for (int k = 0; k <= 10; k++) push(k, fips_rk[k], 1'b1, k + 1, k == 10);
    start_exp(FIPS_KEY, 1'b0);
    wait_drain("after_abort", 1'b0);

`ifdef KEY_EXPAND_DEC_EN
    // Reverse order: round 10 first at T+11, round 0 last, then done.
    for (int i = 0; i <= 10; i++) push(10 - i, fips_rk[10 - i], 1'b1, 11 + i, i == 10);
    start_exp(FIPS_KEY, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_vld", rk_valid, 1'b0);
    check("pre_busy", busy, 1'b1);
    wait_drain("dec", 1'b0);
`else
    // mode_dec is ignored without the decrypt feature: forward order.
    for (int k = 0; k <= 10; k++) push(k, fips_rk[k], 1'b1, k + 1, k == 10);
    start_exp(FIPS_KEY, 1'b1);
    wait_drain("nodec", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
